// File: rtl/id_hazard_unit.sv
// Decode-stage operand fetch with youngest-first forwarding and load-use stall detection.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module id_hazard_unit #(
   parameter int DATA_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH   = 5,
   parameter int NUM_READ_PORTS   = 2,
   parameter int FWD_STAGES       = 3,
   parameter int LOAD_READY_STAGE = 2,
   parameter int MAX_STALL        = 15
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     id_valid,
   input  logic                                     id_flush,
   input  logic                                     id_we,
   input  logic [REG_ADDR_WIDTH-1:0]                id_dest,
   input  logic                                     id_is_load,
   input  logic [NUM_READ_PORTS-1:0]                rd_en,
   input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
   input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     rf_data,
   input  logic [DATA_WIDTH-1:0]                    imm,
   input  logic [FWD_STAGES-1:0]                    fwd_we,
   input  logic [FWD_STAGES*REG_ADDR_WIDTH-1:0]     fwd_addr,
   input  logic [FWD_STAGES*DATA_WIDTH-1:0]         fwd_data,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     operand,
   output logic                                     stall_request,
   output logic                                     issue,
   output logic                                     hazard_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]                              stall_cycles,
   output logic [31:0]                              fwd_hits
`endif
);

   localparam int WD_W = $clog2(MAX_STALL + 1);

   // The destination register is not kept in the shadow: the matching forwarding
   // bus address already identifies it, only validity and load-ness are needed.
   logic [FWD_STAGES-1:0]     sh_valid_q, sh_valid_d;
   logic [FWD_STAGES-1:0]     sh_load_q, sh_load_d;
   logic [WD_W-1:0]           wd_q, wd_d;
   logic                      timeout_q, timeout_d;
   logic [NUM_READ_PORTS-1:0] port_hazard;
   logic [NUM_READ_PORTS-1:0] port_fwd;
   logic                      stall_raw;

   always_comb begin : resolve
      logic [REG_ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0]     res;
      logic                      found;
      port_hazard = '0;
      port_fwd    = '0;
      operand     = '0;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         ra    = rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
         res   = rf_data[p*DATA_WIDTH +: DATA_WIDTH];
         found = 1'b0;
         if (!rd_en[p]) begin
            res = imm;
         end else if (ra == '0) begin
            res = '0;
         end else begin
            for (int s = 0; s < FWD_STAGES; s++) begin
               if (!found && fwd_we[s] &&
                   (fwd_addr[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == ra)) begin
                  found = 1'b1;
                  if (sh_valid_q[s] && sh_load_q[s] && (s < LOAD_READY_STAGE)) begin
                     port_hazard[p] = 1'b1;
                     res            = '0;
                  end else begin
                     port_fwd[p] = 1'b1;
                     res         = fwd_data[s*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         end
         operand[p*DATA_WIDTH +: DATA_WIDTH] = reset ? res : '0;
      end
   end

   // Flush dominates a stall; everything is forced quiet while reset is held.
   assign stall_raw     = id_valid & ~id_flush & (|port_hazard);
   assign stall_request = reset & stall_raw;
   assign issue         = reset & id_valid & ~stall_raw & ~id_flush;
   assign hazard_timeout = timeout_q;

   always_comb begin
      sh_valid_d    = '0;
      sh_load_d     = '0;
      sh_valid_d[0] = issue & id_we & (id_dest != '0);
      sh_load_d[0]  = id_is_load;
      for (int s = 1; s < FWD_STAGES; s++) begin
         sh_valid_d[s] = sh_valid_q[s-1];
         sh_load_d[s]  = sh_load_q[s-1];
      end
      wd_d = '0;
      if (stall_request) begin
         wd_d = (wd_q == WD_W'(MAX_STALL)) ? wd_q : wd_q + 1'b1;
      end
      timeout_d = timeout_q | (wd_d == WD_W'(MAX_STALL));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sh_valid_q <= '0;
         sh_load_q  <= '0;
         wd_q       <= '0;
         timeout_q  <= 1'b0;
      end else begin
         sh_valid_q <= sh_valid_d;
         sh_load_q  <= sh_load_d;
         wd_q       <= wd_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] fwd_hits_q, fwd_hits_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + (stall_request ? 32'd1 : 32'd0);
      fwd_hits_d     = fwd_hits_q + ((issue && (|port_fwd)) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles_q <= '0;
         fwd_hits_q     <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         fwd_hits_q     <= fwd_hits_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign fwd_hits     = fwd_hits_q;
`else
   logic unused_fwd;
   assign unused_fwd = |port_fwd;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Scoreboard bench for id_hazard_unit: stimulus pushes expectations, a negedge monitor checks.
// A second instance with MAX_STALL=2 exercises the watchdog within reachable stall depths.
module tb_id_hazard_unit;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NP = 2;
   localparam int FS = 3;

   logic clock = 1'b1;
   logic reset;
   logic id_valid, id_flush, id_we, id_is_load;
   logic [AW-1:0]    id_dest;
   logic [NP-1:0]    rd_en;
   logic [NP*AW-1:0] rd_addr;
   logic [NP*DW-1:0] rf_data;
   logic [DW-1:0]    imm;
   logic [FS-1:0]    fwd_we;
   logic [FS*AW-1:0] fwd_addr;
   logic [FS*DW-1:0] fwd_data;
   logic [NP*DW-1:0] operand, wd_operand;
   logic stall_request, issue, hazard_timeout;
   logic wd_stall, wd_issue, wd_timeout;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles, fwd_hits, wd_stall_cycles, wd_fwd_hits;
`endif

   always #5 clock = ~clock;

   id_hazard_unit dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
      .id_we(id_we), .id_dest(id_dest), .id_is_load(id_is_load), .rd_en(rd_en),
      .rd_addr(rd_addr), .rf_data(rf_data), .imm(imm), .fwd_we(fwd_we),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .operand(operand),
      .stall_request(stall_request), .issue(issue), .hazard_timeout(hazard_timeout)
`ifdef HAZARD_PERF_EN
      , .stall_cycles(stall_cycles), .fwd_hits(fwd_hits)
`endif
   );

   id_hazard_unit #(.MAX_STALL(2)) dut_wd (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
      .id_we(id_we), .id_dest(id_dest), .id_is_load(id_is_load), .rd_en(rd_en),
      .rd_addr(rd_addr), .rf_data(rf_data), .imm(imm), .fwd_we(fwd_we),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .operand(wd_operand),
      .stall_request(wd_stall), .issue(wd_issue), .hazard_timeout(wd_timeout)
`ifdef HAZARD_PERF_EN
      , .stall_cycles(wd_stall_cycles), .fwd_hits(wd_fwd_hits)
`endif
   );

   typedef struct {
      string         name;
      logic [DW-1:0] op0;
      logic [DW-1:0] op1;
      logic          st;
      logic          is;
      logic          to;
      logic          towd;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string n, input string f, input logic [DW-1:0] act,
                      input logic [DW-1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s.%s: got %h expected %h", n, f, act, want);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp(e.name, "operand0", operand[DW-1:0], e.op0);
         cmp(e.name, "operand1", operand[2*DW-1:DW], e.op1);
         cmp(e.name, "stall", DW'(stall_request), DW'(e.st));
         cmp(e.name, "issue", DW'(issue), DW'(e.is));
         cmp(e.name, "timeout", DW'(hazard_timeout), DW'(e.to));
         cmp(e.name, "timeout_wd", DW'(wd_timeout), DW'(e.towd));
      end
   end

   task automatic expect_out(input string n, input logic [DW-1:0] o0, input logic [DW-1:0] o1,
                             input logic st, input logic is, input logic to, input logic towd);
      exp_t e;
      e.name = n; e.op0 = o0; e.op1 = o1; e.st = st; e.is = is; e.to = to; e.towd = towd;
      sb.push_back(e);
   endtask

   task automatic clr();
      id_valid = 0; id_flush = 0; id_we = 0; id_dest = '0; id_is_load = 0;
      rd_en = '0; rd_addr = '0; imm = '0;
      rf_data = {32'h0000_F001, 32'h0000_F000};
      fwd_we = '0; fwd_addr = '0; fwd_data = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      clr();
   endtask

   task automatic dec(input logic v, input logic we, input logic [AW-1:0] d, input logic ld);
      id_valid = v; id_we = we; id_dest = d; id_is_load = ld;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic fwd(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
      fwd_we[s] = 1'b1;
      fwd_addr[s*AW +: AW] = a;
      fwd_data[s*DW +: DW] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      // C0: in reset with a live read request
      reset = 0; clr();
      dec(1, 1, 5'd3, 0); rd(0, 5'd3); fwd(0, 5'd3, 32'h1234); imm = 32'h55;
      expect_out("in_reset", 0, 0, 0, 0, 0, 0);
      tick(); reset = 1;
      expect_out("idle", 0, 0, 0, 0, 0, 0);
      // Test 1: ALU result forwarded from EX
      tick(); dec(1, 1, 5'd3, 0); imm = 32'h77;
      expect_out("addi_issue", 32'h77, 32'h77, 0, 1, 0, 0);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd3); fwd(0, 5'd3, 32'h1234); rd(1, 5'd9);
      expect_out("fwd_ex", 32'h1234, 32'h0000_F001, 0, 1, 0, 0);
      // Test 2: load-use stall for two cycles
      tick(); dec(1, 1, 5'd5, 1);
      expect_out("lw_issue", 0, 0, 0, 1, 0, 0);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd5); fwd(0, 5'd5, 32'hDEAD_0000); rd(1, 5'd6);
      expect_out("lu_stall0", 0, 32'h0000_F001, 1, 0, 0, 0);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd5); fwd(1, 5'd5, 32'hDEAD_0001);
      expect_out("lu_stall1", 0, 0, 1, 0, 0, 0);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd5); fwd(2, 5'd5, 32'hDEAD_0002);
      expect_out("lu_release", 32'hDEAD_0002, 0, 0, 1, 0, 1);
      // Test 3: youngest wins, r0 never forwards
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd7); fwd(0, 5'd7, 32'hAAAA); fwd(2, 5'd7, 32'hBBBB);
      rd(1, 5'd0); fwd(1, 5'd0, 32'hCCCC);
      expect_out("youngest", 32'hAAAA, 0, 0, 1, 0, 1);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd0); fwd(0, 5'd0, 32'h1111); rd(1, 5'd4);
      expect_out("r0_zero", 0, 32'h0000_F001, 0, 1, 0, 1);
      // Test 4: flush overrides a load-use stall and inserts a bubble
      tick(); dec(1, 1, 5'd5, 1);
      expect_out("lw2_issue", 0, 0, 0, 1, 0, 1);
      tick(); dec(1, 1, 5'd8, 1); id_flush = 1; rd(0, 5'd5); fwd(0, 5'd5, 32'h5555);
      expect_out("flush_stall", 0, 0, 0, 0, 0, 1);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd8); fwd(0, 5'd8, 32'h8888);
      expect_out("flush_bubble", 32'h8888, 0, 0, 1, 0, 1);
      // Test 6: reset in the middle of a load stall
      tick(); dec(1, 1, 5'd6, 1);
      expect_out("lw3_issue", 0, 0, 0, 1, 0, 1);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd6); fwd(0, 5'd6, 32'h6666);
      expect_out("pre_reset_stall", 0, 0, 1, 0, 0, 1);
      tick(); reset = 0; dec(1, 0, 5'd0, 0); rd(0, 5'd6); fwd(1, 5'd6, 32'h6666); imm = 32'h99;
      expect_out("reset_mid_stall", 0, 0, 0, 0, 0, 0);
      tick(); reset = 1; dec(1, 0, 5'd0, 0); rd(0, 5'd6); imm = 32'h99;
      expect_out("post_reset_read", 32'h0000_F000, 32'h99, 0, 1, 0, 0);
      // Watchdog clears on a non-stall cycle between single stalls
      tick(); dec(1, 1, 5'd5, 1);
      expect_out("wd_lw_a", 0, 0, 0, 1, 0, 0);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd5); fwd(0, 5'd5, 32'h1);
      expect_out("wd_stall_a", 0, 0, 1, 0, 0, 0);
      tick(); dec(1, 1, 5'd5, 1);
      expect_out("wd_lw_b", 0, 0, 0, 1, 0, 0);
      tick(); dec(1, 0, 5'd0, 0); rd(0, 5'd5); fwd(0, 5'd5, 32'h2);
      expect_out("wd_stall_b", 0, 0, 1, 0, 0, 0);
      tick();
      expect_out("wd_cleared", 0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
